// File: rtl/cu_pkg.sv
// Shared types and encodings for the basic CPU control unit: state enum,
// bus selects, ALU codes, opcodes and register-reference bit positions.
package cu_pkg;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [3:0] ALU_AND     = 4'h0;
    localparam logic [3:0] ALU_ADD     = 4'h1;
    localparam logic [3:0] ALU_PASS_DR = 4'h2;
    localparam logic [3:0] ALU_CMA     = 4'h3;
    localparam logic [3:0] ALU_CIR     = 4'h4;
    localparam logic [3:0] ALU_CIL     = 4'h5;
    localparam logic [3:0] ALU_CLE     = 4'h6;
    localparam logic [3:0] ALU_CME     = 4'h7;
    localparam logic [3:0] ALU_NOP     = 4'hF;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

endpackage

// File: rtl/cu_rr_decode.sv
// Register-reference decode: only the highest set bit of ir[11:0] acts;
// skip instructions turn into a conditional PC increment.
module cu_rr_decode
    import cu_pkg::*;
(
    input  logic [11:0] i_rr,
    input  logic        i_ac_msb,
    input  logic        i_ac_zero,
    input  logic        i_e_flag,
    output logic        o_clr_ac,
    output logic        o_ld_ac,
    output logic        o_inr_ac,
    output logic        o_upd_e,
    output logic        o_inr_pc,
    output logic        o_hlt,
    output logic [3:0]  o_aluop
);

    always_comb begin
        o_clr_ac = 1'b0;
        o_ld_ac  = 1'b0;
        o_inr_ac = 1'b0;
        o_upd_e  = 1'b0;
        o_inr_pc = 1'b0;
        o_hlt    = 1'b0;
        o_aluop  = ALU_NOP;
        if (i_rr[RR_CLA]) begin
            o_clr_ac = 1'b1;
        end else if (i_rr[RR_CLE]) begin
            o_aluop = ALU_CLE;
            o_upd_e = 1'b1;
        end else if (i_rr[RR_CMA]) begin
            o_aluop = ALU_CMA;
            o_ld_ac = 1'b1;
        end else if (i_rr[RR_CME]) begin
            o_aluop = ALU_CME;
            o_upd_e = 1'b1;
        end else if (i_rr[RR_CIR]) begin
            o_aluop = ALU_CIR;
            o_ld_ac = 1'b1;
            o_upd_e = 1'b1;
        end else if (i_rr[RR_CIL]) begin
            o_aluop = ALU_CIL;
            o_ld_ac = 1'b1;
            o_upd_e = 1'b1;
        end else if (i_rr[RR_INC]) begin
            o_inr_ac = 1'b1;
        end else if (i_rr[RR_SPA]) begin
            o_inr_pc = !i_ac_msb;
        end else if (i_rr[RR_SNA]) begin
            o_inr_pc = i_ac_msb;
        end else if (i_rr[RR_SZA]) begin
            o_inr_pc = i_ac_zero;
        end else if (i_rr[RR_SZE]) begin
            o_inr_pc = !i_e_flag;
        end else if (i_rr[RR_HLT]) begin
            o_hlt = 1'b1;
        end
    end

endmodule

// File: rtl/basic_cpu_control_unit.sv
// Hardwired fetch/decode/indirect/execute sequencer for the accumulator datapath.
// Optional CU_SINGLE_STEP_EN adds a 'step' input that gates each instruction at T0.
module basic_cpu_control_unit
    import cu_pkg::*;
#(
    parameter int wsize = 16,
    parameter int addr  = 12
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
`ifdef CU_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [wsize-1:0] ir,
    input  logic             ac_msb,
    input  logic             ac_zero,
    input  logic             dr_zero,
    input  logic             e_flag,
    output logic [2:0]       s,
    output logic             ldAR,
    output logic             ldPC,
    output logic             ldDR,
    output logic             ldAC,
    output logic             ldIR,
    output logic             ldTR,
    output logic             clrAR,
    output logic             clrPC,
    output logic             clrDR,
    output logic             clrAC,
    output logic             clrTR,
    output logic             inrAR,
    output logic             inrPC,
    output logic             inrDR,
    output logic             inrAC,
    output logic             inrTR,
    output logic [3:0]       aluop,
    output logic             updE,
    output logic             memread,
    output logic             memwrite,
    output logic             I,
    output logic             halted
);

    state_t     r_state, w_next;
    logic       r_I;
    logic [2:0] w_opcode;
    logic       w_go;
    logic       w_rr_clr_ac, w_rr_ld_ac, w_rr_inr_ac, w_rr_upd_e, w_rr_inr_pc, w_rr_hlt;
    logic [3:0] w_rr_aluop;

    assign w_opcode = ir[wsize-2 -: 3];
    assign I        = r_I;

`ifdef CU_SINGLE_STEP_EN
    assign w_go = step;
`else
    assign w_go = 1'b1;
`endif

    cu_rr_decode u_rr (
        .i_rr      (ir[addr-1:0]),
        .i_ac_msb  (ac_msb),
        .i_ac_zero (ac_zero),
        .i_e_flag  (e_flag),
        .o_clr_ac  (w_rr_clr_ac),
        .o_ld_ac   (w_rr_ld_ac),
        .o_inr_ac  (w_rr_inr_ac),
        .o_upd_e   (w_rr_upd_e),
        .o_inr_pc  (w_rr_inr_pc),
        .o_hlt     (w_rr_hlt),
        .o_aluop   (w_rr_aluop)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_I     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == T2) r_I <= ir[wsize-1];
        end
    end

    always_comb begin
        w_next   = r_state;
        s        = BUS_NONE;
        ldAR     = 1'b0;  ldPC  = 1'b0;  ldDR  = 1'b0;
        ldAC     = 1'b0;  ldIR  = 1'b0;  ldTR  = 1'b0;
        clrAR    = 1'b0;  clrPC = 1'b0;  clrDR = 1'b0;
        clrAC    = 1'b0;  clrTR = 1'b0;
        inrAR    = 1'b0;  inrPC = 1'b0;  inrDR = 1'b0;
        inrAC    = 1'b0;  inrTR = 1'b0;
        aluop    = ALU_NOP;
        updE     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        halted   = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = T0;
            T0: if (w_go) begin
                s      = BUS_PC;
                ldAR   = 1'b1;
                w_next = T1;
            end
            T1: begin
                s       = BUS_MEM;
                memread = 1'b1;
                ldIR    = 1'b1;
                inrPC   = 1'b1;
                w_next  = T2;
            end
            T2: begin
                s      = BUS_IR;
                ldAR   = 1'b1;
                w_next = T3;
            end
            T3: begin
                if (w_opcode != OP_REG) begin
                    w_next = T4;
                    if (r_I) begin
                        s       = BUS_MEM;
                        memread = 1'b1;
                        ldAR    = 1'b1;
                    end
                end else begin
                    w_next = T0;
                    // I/O instructions (I=1) are treated as NOP
                    if (!r_I) begin
                        clrAC = w_rr_clr_ac;
                        ldAC  = w_rr_ld_ac;
                        inrAC = w_rr_inr_ac;
                        updE  = w_rr_upd_e;
                        inrPC = w_rr_inr_pc;
                        aluop = w_rr_aluop;
                        if (w_rr_hlt) w_next = HALT;
                    end
                end
            end
            T4: begin
                w_next = T0;
                case (w_opcode)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                        s       = BUS_MEM;
                        memread = 1'b1;
                        ldDR    = 1'b1;
                        w_next  = T5;
                    end
                    OP_STA: begin
                        s        = BUS_AC;
                        memwrite = 1'b1;
                    end
                    OP_BUN: begin
                        s    = BUS_AR;
                        ldPC = 1'b1;
                    end
                    OP_BSA: begin
                        s        = BUS_PC;
                        memwrite = 1'b1;
                        inrAR    = 1'b1;
                        w_next   = T5;
                    end
                    default: ;
                endcase
            end
            T5: begin
                w_next = T0;
                case (w_opcode)
                    OP_AND: begin aluop = ALU_AND;     ldAC = 1'b1; updE = 1'b1; end
                    OP_ADD: begin aluop = ALU_ADD;     ldAC = 1'b1; updE = 1'b1; end
                    OP_LDA: begin aluop = ALU_PASS_DR; ldAC = 1'b1; end
                    OP_BSA: begin s = BUS_AR; ldPC = 1'b1; end
                    OP_ISZ: begin inrDR = 1'b1; w_next = T6; end
                    default: ;
                endcase
            end
            T6: begin
                // DR already incremented, so dr_zero reflects the new value
                s        = BUS_DR;
                memwrite = 1'b1;
                inrPC    = dr_zero;
                w_next   = T0;
            end
            HALT: begin
                halted = 1'b1;
                if (start) w_next = T0;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_basic_cpu_control_unit.sv
// Bench for basic_cpu_control_unit: per-step decode vectors with ir/flags driven
// directly, plus short programs run on a behavioural datapath/memory model.
module tb_basic_cpu_control_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start;
    logic        step;
    logic [15:0] ir;
    logic        ac_msb, ac_zero, dr_zero, e_flag;
    logic [2:0]  s;
    logic        ldAR, ldPC, ldDR, ldAC, ldIR, ldTR;
    logic        clrAR, clrPC, clrDR, clrAC, clrTR;
    logic        inrAR, inrPC, inrDR, inrAC, inrTR;
    logic [3:0]  aluop;
    logic        updE, memread, memwrite, I, halted;

    always #5 CLK = ~CLK;

    basic_cpu_control_unit dut (
        .CLK(CLK), .RST_N(RST_N), .start(start),
`ifdef CU_SINGLE_STEP_EN
        .step(step),
`endif
        .ir(ir), .ac_msb(ac_msb), .ac_zero(ac_zero), .dr_zero(dr_zero), .e_flag(e_flag),
        .s(s), .ldAR(ldAR), .ldPC(ldPC), .ldDR(ldDR), .ldAC(ldAC), .ldIR(ldIR), .ldTR(ldTR),
        .clrAR(clrAR), .clrPC(clrPC), .clrDR(clrDR), .clrAC(clrAC), .clrTR(clrTR),
        .inrAR(inrAR), .inrPC(inrPC), .inrDR(inrDR), .inrAC(inrAC), .inrTR(inrTR),
        .aluop(aluop), .updE(updE), .memread(memread), .memwrite(memwrite),
        .I(I), .halted(halted)
    );

    localparam logic [5:0] LD_AR = 6'b100000, LD_PC = 6'b010000, LD_DR = 6'b001000,
                           LD_AC = 6'b000100, LD_IR = 6'b000010;
    localparam logic [4:0] C_AR = 5'b10000, C_PC = 5'b01000, C_DR = 5'b00100, C_AC = 5'b00010;

    function automatic logic [25:0] pack(input logic [2:0] bs, input logic [5:0] ld,
                                         input logic [4:0] clr, input logic [4:0] inr,
                                         input logic [3:0] alu, input logic upd,
                                         input logic mr, input logic mw);
        return {bs, ld, clr, inr, alu, upd, mr, mw};
    endfunction

    logic [25:0] outv;
    assign outv = {s, ldAR, ldPC, ldDR, ldAC, ldIR, ldTR, clrAR, clrPC, clrDR, clrAC, clrTR,
                   inrAR, inrPC, inrDR, inrAC, inrTR, aluop, updE, memread, memwrite};

    // ---- behavioural datapath + memory ----
    logic        use_model, load_req;
    logic [15:0] prog [0:255];
    logic [15:0] mem  [0:255];
    logic [15:0] init_ac;
    logic [11:0] mAR, mPC;
    logic [15:0] mDR, mAC, mIR, bus, alu_ac;
    logic        mE, alu_e;
    logic [15:0] ir_drv;
    logic [3:0]  fl_drv;

    always_comb begin
        case (s)
            3'd1:    bus = {4'h0, mAR};
            3'd2:    bus = {4'h0, mPC};
            3'd3:    bus = mDR;
            3'd4:    bus = mAC;
            3'd5:    bus = mIR;
            3'd7:    bus = mem[mAR[7:0]];
            default: bus = 16'h0000;
        endcase
    end

    always_comb begin
        alu_ac = mAC;
        alu_e  = mE;
        case (aluop)
            4'h0: alu_ac = mAC & mDR;
            4'h1: {alu_e, alu_ac} = {1'b0, mAC} + {1'b0, mDR};
            4'h2: alu_ac = mDR;
            4'h3: alu_ac = ~mAC;
            4'h4: {alu_ac, alu_e} = {mE, mAC};
            4'h5: {alu_e, alu_ac} = {mAC, mE};
            4'h6: alu_e = 1'b0;
            4'h7: alu_e = ~mE;
            default: ;
        endcase
    end

    always_comb begin
        ir      = use_model ? mIR : ir_drv;
        ac_msb  = use_model ? mAC[15] : fl_drv[3];
        ac_zero = use_model ? (mAC == 16'h0) : fl_drv[2];
        dr_zero = use_model ? (mDR == 16'h0) : fl_drv[1];
        e_flag  = use_model ? mE : fl_drv[0];
    end

    always @(posedge CLK) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
            mAR <= '0; mPC <= '0; mDR <= '0; mAC <= init_ac; mIR <= '0; mE <= 1'b0;
        end else if (use_model) begin
            if (memwrite) mem[mAR[7:0]] <= bus;
            if (ldAR) mAR <= bus[11:0]; else if (inrAR) mAR <= mAR + 12'd1;
            if (ldPC) mPC <= bus[11:0]; else if (inrPC) mPC <= mPC + 12'd1;
            if (ldDR) mDR <= bus;       else if (inrDR) mDR <= mDR + 16'd1;
            if (ldAC) mAC <= alu_ac;
            else if (clrAC) mAC <= 16'h0;
            else if (inrAC) mAC <= mAC + 16'd1;
            if (ldIR) mIR <= bus;
            if (updE) mE <= alu_e;
        end
    end

    // ---- checking ----
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       nm;
        logic [15:0] ir;
        logic [3:0]  fl;     // {ac_msb, ac_zero, dr_zero, e_flag}
        int          t;
        logic [25:0] exp;
    } vec_t;
    vec_t vq[$];

    task automatic addv(input string nm, input logic [15:0] vir, input logic [3:0] fl, input int t,
                        input logic [2:0] bs, input logic [5:0] ld, input logic [4:0] clr,
                        input logic [4:0] inr, input logic [3:0] alu, input logic upd,
                        input logic mr, input logic mw);
        vec_t v;
        v.nm = nm; v.ir = vir; v.fl = fl; v.t = t;
        v.exp = pack(bs, ld, clr, inr, alu, upd, mr, mw);
        vq.push_back(v);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic load(input logic [15:0] acv);
        init_ac  = acv;
        load_req = 1'b1;
        @(negedge CLK);
        load_req = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic run_until_halt(output int cnt);
        pulse_start();
        cnt = 1;
        while (!halted && cnt < 200) begin
            @(negedge CLK);
            cnt++;
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    endtask

    int cnt;

    initial begin
        RST_N = 1'b0; start = 1'b0; step = 1'b1;
        use_model = 1'b0; load_req = 1'b0; init_ac = '0;
        ir_drv = '0; fl_drv = '0;
        clear_prog();

        addv("T0_fetch",   16'h2005, 4'b0000, 0, 3'd2, LD_AR, 0, 0,    4'hF, 0, 0, 0);
        addv("T1_fetch",   16'h2005, 4'b0000, 1, 3'd7, LD_IR, 0, C_PC, 4'hF, 0, 1, 0);
        addv("T2_decode",  16'h2005, 4'b0000, 2, 3'd5, LD_AR, 0, 0,    4'hF, 0, 0, 0);
        addv("T3_direct",  16'h2005, 4'b0000, 3, 3'd0, 0,     0, 0,    4'hF, 0, 0, 0);
        addv("T3_indir",   16'hA020, 4'b0000, 3, 3'd7, LD_AR, 0, 0,    4'hF, 0, 1, 0);
        addv("T4_lda",     16'h2005, 4'b0000, 4, 3'd7, LD_DR, 0, 0,    4'hF, 0, 1, 0);
        addv("T5_lda",     16'h2005, 4'b0000, 5, 3'd0, LD_AC, 0, 0,    4'h2, 0, 0, 0);
        addv("T5_add",     16'h1006, 4'b0000, 5, 3'd0, LD_AC, 0, 0,    4'h1, 1, 0, 0);
        addv("T5_and",     16'h0006, 4'b0000, 5, 3'd0, LD_AC, 0, 0,    4'h0, 1, 0, 0);
        addv("T4_sta",     16'h3006, 4'b0000, 4, 3'd4, 0,     0, 0,    4'hF, 0, 0, 1);
        addv("T4_bun",     16'h4006, 4'b0000, 4, 3'd1, LD_PC, 0, 0,    4'hF, 0, 0, 0);
        addv("T4_bsa",     16'h5010, 4'b0000, 4, 3'd2, 0,     0, C_AR, 4'hF, 0, 0, 1);
        addv("T5_bsa",     16'h5010, 4'b0000, 5, 3'd1, LD_PC, 0, 0,    4'hF, 0, 0, 0);
        addv("T5_isz",     16'h6008, 4'b0000, 5, 3'd0, 0,     0, C_DR, 4'hF, 0, 0, 0);
        addv("T6_isz_z",   16'h6008, 4'b0010, 6, 3'd3, 0,     0, C_PC, 4'hF, 0, 0, 1);
        addv("T6_isz_nz",  16'h6008, 4'b0000, 6, 3'd3, 0,     0, 0,    4'hF, 0, 0, 1);
        addv("rr_7C00",    16'h7C00, 4'b0000, 3, 3'd0, 0,  C_AC, 0,    4'hF, 0, 0, 0);
        addv("rr_cma",     16'h7200, 4'b0000, 3, 3'd0, LD_AC, 0, 0,    4'h3, 0, 0, 0);
        addv("rr_cme",     16'h7100, 4'b0000, 3, 3'd0, 0,     0, 0,    4'h7, 1, 0, 0);
        addv("rr_cle",     16'h7400, 4'b0000, 3, 3'd0, 0,     0, 0,    4'h6, 1, 0, 0);
        addv("rr_cir",     16'h7080, 4'b0000, 3, 3'd0, LD_AC, 0, 0,    4'h4, 1, 0, 0);
        addv("rr_cil",     16'h7040, 4'b0000, 3, 3'd0, LD_AC, 0, 0,    4'h5, 1, 0, 0);
        addv("rr_inc",     16'h7020, 4'b0000, 3, 3'd0, 0,     0, C_AC, 4'hF, 0, 0, 0);
        addv("rr_spa_t",   16'h7010, 4'b0000, 3, 3'd0, 0,     0, C_PC, 4'hF, 0, 0, 0);
        addv("rr_spa_f",   16'h7010, 4'b1000, 3, 3'd0, 0,     0, 0,    4'hF, 0, 0, 0);
        addv("rr_sna_t",   16'h7008, 4'b1000, 3, 3'd0, 0,     0, C_PC, 4'hF, 0, 0, 0);
        addv("rr_sza_t",   16'h7004, 4'b0100, 3, 3'd0, 0,     0, C_PC, 4'hF, 0, 0, 0);
        addv("rr_sza_f",   16'h7004, 4'b0000, 3, 3'd0, 0,     0, 0,    4'hF, 0, 0, 0);
        addv("rr_sze_t",   16'h7002, 4'b0000, 3, 3'd0, 0,     0, C_PC, 4'hF, 0, 0, 0);
        addv("rr_sze_f",   16'h7002, 4'b0001, 3, 3'd0, 0,     0, 0,    4'hF, 0, 0, 0);
        addv("rr_nop",     16'h7000, 4'b0000, 3, 3'd0, 0,     0, 0,    4'hF, 0, 0, 0);
        addv("io_nop",     16'hF800, 4'b0000, 3, 3'd0, 0,     0, 0,    4'hF, 0, 0, 0);
        addv("rr_hlt",     16'h7001, 4'b0000, 3, 3'd0, 0,     0, 0,    4'hF, 0, 0, 0);

        // reset state
        @(negedge CLK);
        chk("reset_outs", outv, pack(0, 0, 0, 0, 4'hF, 0, 0, 0));
        chk("reset_halted", halted, 0);
        chk("reset_I", I, 0);

        // decode vectors, ir/flags held constant
        foreach (vq[k]) begin
            do_reset();
            ir_drv = vq[k].ir;
            fl_drv = vq[k].fl;
            start  = 1'b1;
            @(negedge CLK);
            repeat (vq[k].t) @(negedge CLK);
            chk(vq[k].nm, outv, vq[k].exp);
            if (vq[k].t >= 3) chk({vq[k].nm, "_I"}, I, vq[k].ir[15]);
        end

        use_model = 1'b1;

        // LDA 5; ADD 6; HLT
        do_reset();
        clear_prog();
        prog[0] = 16'h2005; prog[1] = 16'h1006; prog[2] = 16'h7001; prog[3] = 16'h7001;
        prog[5] = 16'h0003; prog[6] = 16'h0004;
        load(16'h0000);
        run_until_halt(cnt);
        chk("prog_cycles", cnt, 17);
        chk("prog_ac", mAC, 16'h0007);
        chk("prog_halted", halted, 1);
        chk("prog_pc", mPC, 12'h003);
        @(negedge CLK);
        chk("halt_outs", outv, pack(0, 0, 0, 0, 4'hF, 0, 0, 0));
        run_until_halt(cnt);
        chk("resume_cycles", cnt, 5);
        chk("resume_pc", mPC, 12'h004);

        // ISZ with M[8]=FFFF skips once
        do_reset();
        clear_prog();
        prog[0] = 16'h6008; prog[1] = 16'h7001; prog[2] = 16'h7001; prog[8] = 16'hFFFF;
        load(16'h0000);
        pulse_start();
        repeat (6) @(negedge CLK);
        chk("isz_t6_mw", memwrite, 1);
        chk("isz_t6_bus", bus, 16'h0000);
        chk("isz_t6_inrpc", inrPC, 1);
        cnt = 0;
        while (!halted && cnt < 100) begin
            @(negedge CLK);
            cnt++;
        end
        chk("isz_halted", halted, 1);
        chk("isz_pc", mPC, 12'h003);
        chk("isz_mem", mem[8], 16'h0000);

        // BSA 010
        do_reset();
        clear_prog();
        prog[0] = 16'h5010; prog[17] = 16'h7001;
        load(16'h0000);
        run_until_halt(cnt);
        chk("bsa_cycles", cnt, 11);
        chk("bsa_mem", mem[16], 16'h0001);
        chk("bsa_pc", mPC, 12'h012);

        // indirect LDA through M[020]
        do_reset();
        clear_prog();
        prog[0] = 16'hA020; prog[1] = 16'h7001; prog[32] = 16'h0030; prog[48] = 16'h1234;
        load(16'h0000);
        run_until_halt(cnt);
        chk("ind_cycles", cnt, 11);
        chk("ind_ac", mAC, 16'h1234);

        // reset during T5 of ADD
        do_reset();
        clear_prog();
        prog[0] = 16'h1006; prog[6] = 16'h0004;
        load(16'h0005);
        pulse_start();
        repeat (5) @(negedge CLK);
        chk("add_t5_ldac", ldAC, 1);
        chk("add_t5_alu", aluop, 4'h1);
        #1 RST_N = 1'b0;
        #1;
        chk("rst_outs", outv, pack(0, 0, 0, 0, 4'hF, 0, 0, 0));
        chk("rst_halted", halted, 0);
        @(posedge CLK);
        #1;
        chk("rst_ac_kept", mAC, 16'h0005);
        RST_N = 1'b1;

`ifdef CU_SINGLE_STEP_EN
        // single-step gate at T0
        do_reset();
        clear_prog();
        prog[0] = 16'h2005; prog[1] = 16'h7001; prog[5] = 16'h0003;
        load(16'h0000);
        step = 1'b0;
        pulse_start();
        repeat (20) @(negedge CLK);
        chk("step_hold_outs", outv, pack(0, 0, 0, 0, 4'hF, 0, 0, 0));
        chk("step_hold_pc", mPC, 12'h000);
        step = 1'b1;
        @(negedge CLK);
        step = 1'b0;
        repeat (12) @(negedge CLK);
        chk("step_one_ac", mAC, 16'h0003);
        chk("step_one_pc", mPC, 12'h001);
        chk("step_one_halted", halted, 0);
        step = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
